// File: rtl/clk_en_pkg.sv
// Shared definitions for the clock-enable bank: global mode encoding.
package clk_en_pkg;

  typedef enum logic [1:0] {
    MODE_STOP  = 2'b00,
    MODE_RUN   = 2'b01,
    MODE_STEP  = 2'b10,
    MODE_ALIGN = 2'b11
  } mode_e;

endpackage

// File: rtl/clk_en_chan.sv
// One enable channel: programmable divisor, free-running counter, registered
// enable pulse and matching toggle output.
module clk_en_chan #(
  parameter int CNT_W   = 32,
  parameter int DEF_DIV = 3
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             step_fire,
  input  logic             align,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             en,
  output logic             tog
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic             r_en;
  logic             r_tog;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_div_nxt;
  logic             w_en_nxt;
  logic             w_tog_nxt;
  logic             w_active;
  logic             w_wrap;

  assign w_active = (r_div != {CNT_W{1'b0}});
  assign w_wrap   = (r_cnt == (r_div - CNT_W'(1)));

  // Next-state selection; a divisor write replaces the counter advance
  // but never cancels a step pulse.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_div_nxt = r_div;
    w_en_nxt  = 1'b0;
    w_tog_nxt = r_tog;
    if (align) begin
      w_cnt_nxt = {CNT_W{1'b0}};
      w_tog_nxt = 1'b0;
    end else if (step_fire) begin
      w_en_nxt  = w_active;
      w_tog_nxt = r_tog ^ w_active;
    end else if (advance && !wr) begin
      if (!w_active) begin
        w_cnt_nxt = {CNT_W{1'b0}};
      end else if (w_wrap) begin
        w_cnt_nxt = {CNT_W{1'b0}};
        w_en_nxt  = 1'b1;
        w_tog_nxt = ~r_tog;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end else begin
      w_cnt_nxt = r_cnt;
    end
    if (wr) begin
      w_div_nxt = wr_div;
      w_cnt_nxt = {CNT_W{1'b0}};
    end else begin
      w_div_nxt = r_div;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= {CNT_W{1'b0}};
      r_div <= CNT_W'(DEF_DIV);
      r_en  <= 1'b0;
      r_tog <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_div <= w_div_nxt;
      r_en  <= w_en_nxt;
      r_tog <= w_tog_nxt;
    end
  end

  assign en  = r_en;
  assign tog = r_tog;

endmodule

// File: rtl/clk_en_bank.sv
// Bank of NCH programmable clock-enable channels with run/stop/step/align
// control, step-switch synchroniser and divisor write port.
module clk_en_bank
  import clk_en_pkg::*;
#(
  parameter int NCH     = 5,
  parameter int CNT_W   = 32,
  parameter int DEF_DIV = 3
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic                   step_in,
  input  logic                   cfg_we,
  input  logic [$clog2(NCH)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]       cfg_div,
  output logic [NCH-1:0]         en,
  output logic [NCH-1:0]         tog,
  output logic                   step_ack,
  output logic                   cfg_err
);

  localparam int CH_W = $clog2(NCH);
  localparam logic [CH_W:0] NCH_L = (CH_W+1)'(NCH);

  logic r_sync1;
  logic r_sync2;
  logic r_edge;
  logic r_rise;
  logic r_step_ack;
  logic r_cfg_err;
  logic w_advance;
  logic w_align;
  logic w_step_fire;
  logic w_cfg_bad;

  assign w_advance   = (mode == MODE_RUN);
  assign w_align     = (mode == MODE_ALIGN);
  // An edge seen outside STEP mode simply expires here; it is never queued.
  assign w_step_fire = r_rise && (mode == MODE_STEP);
  assign w_cfg_bad   = ({1'b0, cfg_ch} >= NCH_L);

  // Step synchroniser, registered rising-edge detect and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_edge     <= 1'b0;
      r_rise     <= 1'b0;
      r_step_ack <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_sync1    <= step_in;
      r_sync2    <= r_sync1;
      r_edge     <= r_sync2;
      r_rise     <= r_sync2 & ~r_edge;
      r_step_ack <= w_step_fire;
      r_cfg_err  <= cfg_we & w_cfg_bad;
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    clk_en_chan #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .advance   (w_advance),
      .step_fire (w_step_fire),
      .align     (w_align),
      .wr        (cfg_we && (cfg_ch == CH_W'(gi))),
      .wr_div    (cfg_div),
      .en        (en[gi]),
      .tog       (tog[gi])
    );
  end

  assign step_ack = r_step_ack;
  assign cfg_err  = r_cfg_err;

endmodule

// File: tb/tb_clk_en_bank.sv
// Self-checking bench for clk_en_bank: cycle scoreboard against a behavioural
// model, a config-write vector table and hand-derived timing sequences.
module tb_clk_en_bank;

  localparam int NCH     = 5;
  localparam int CNT_W   = 32;
  localparam int DEF_DIV = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        mode;
  logic              step_in;
  logic              cfg_we;
  logic [2:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic [NCH-1:0]    en;
  logic [NCH-1:0]    tog;
  logic              step_ack;
  logic              cfg_err;

  always #5 clk = ~clk;

  clk_en_bank #(.NCH(NCH), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .step_in  (step_in),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .en       (en),
    .tog      (tog),
    .step_ack (step_ack),
    .cfg_err  (cfg_err)
  );

  typedef struct packed {
    logic [NCH-1:0] en;
    logic [NCH-1:0] tog;
    logic           ack;
    logic           err;
  } obs_t;

  typedef struct {
    logic [2:0]       ch;
    logic [CNT_W-1:0] div;
    logic             exp_err;
  } vec_t;

  obs_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  int unsigned    m_cnt [NCH];
  int unsigned    m_div [NCH];
  logic [NCH-1:0] m_en;
  logic [NCH-1:0] m_tog;
  logic           m_s1, m_s2, m_s3, m_rise, m_ack, m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: one clock edge with the inputs currently driven.
  task automatic model_edge();
    logic fire;
    logic nr;
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_cnt[i] = 0;
        m_div[i] = DEF_DIV;
      end
      m_en = '0; m_tog = '0;
      m_s1 = 1'b0; m_s2 = 1'b0; m_s3 = 1'b0; m_rise = 1'b0;
      m_ack = 1'b0; m_err = 1'b0;
    end else begin
      fire   = m_rise && (mode == 2'b10);
      nr     = m_s2 && !m_s3;
      m_s3   = m_s2;
      m_s2   = m_s1;
      m_s1   = step_in;
      m_rise = nr;
      m_ack  = fire;
      m_err  = cfg_we && (cfg_ch >= 3'd5);
      for (int i = 0; i < NCH; i++) begin
        case (mode)
          2'b11: begin
            m_cnt[i] = 0; m_tog[i] = 1'b0; m_en[i] = 1'b0;
          end
          2'b10: begin
            m_en[i]  = fire && (m_div[i] != 0);
            m_tog[i] = m_tog[i] ^ m_en[i];
          end
          2'b01: begin
            m_en[i] = 1'b0;
            if (!(cfg_we && int'(cfg_ch) == i) && m_div[i] != 0) begin
              if (m_cnt[i] + 1 == m_div[i]) begin
                m_cnt[i] = 0; m_en[i] = 1'b1; m_tog[i] = ~m_tog[i];
              end else begin
                m_cnt[i] = m_cnt[i] + 1;
              end
            end
          end
          default: m_en[i] = 1'b0;
        endcase
        if (cfg_we && int'(cfg_ch) == i) begin
          m_div[i] = cfg_div;
          m_cnt[i] = 0;
        end
      end
    end
  endtask

  task automatic tick();
    obs_t e;
    obs_t got;
    @(posedge clk);
    model_edge();
    sb_q.push_back({m_en, m_tog, m_ack, m_err});
    #1;
    e   = sb_q.pop_front();
    got = {en, tog, step_ack, cfg_err};
    check("scoreboard", 32'(got), 32'(e));
  endtask

  task automatic do_reset();
    rst = 1'b1; mode = 2'b01; step_in = 1'b0; cfg_we = 1'b0; cfg_ch = 3'd0; cfg_div = 32'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic write_cfg(input logic [2:0] ch, input logic [CNT_W-1:0] div);
    cfg_we = 1'b1; cfg_ch = ch; cfg_div = div;
    tick();
    cfg_we = 1'b0;
  endtask

  vec_t tbl [5];

  initial begin
    tbl[0] = '{ch: 3'd7, div: 32'd9, exp_err: 1'b1};
    tbl[1] = '{ch: 3'd5, div: 32'd1, exp_err: 1'b1};
    tbl[2] = '{ch: 3'd6, div: 32'd0, exp_err: 1'b1};
    tbl[3] = '{ch: 3'd1, div: 32'd3, exp_err: 1'b0};
    tbl[4] = '{ch: 3'd7, div: 32'd2, exp_err: 1'b1};

    // Reset defaults and divide-by-3 cadence
    do_reset();
    check("rst_en", 32'(en), 32'd0);
    check("rst_tog", 32'(tog), 32'd0);
    check("rst_ack", 32'(step_ack), 32'd0);
    check("rst_err", 32'(cfg_err), 32'd0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      check("dflt_en", 32'(en), (k % 3 == 0) ? 32'h1f : 32'h0);
      check("dflt_tog", 32'(tog), (((k / 3) % 2) == 1) ? 32'h1f : 32'h0);
    end

    // Reprogram channel 2 to divide-by-5 on cycle 10
    for (int k = 10; k <= 25; k++) begin
      if (k == 10) begin
        cfg_we = 1'b1; cfg_ch = 3'd2; cfg_div = 32'd5;
      end else begin
        cfg_we = 1'b0;
      end
      tick();
      check("reprog_en2", 32'(en[2]), 32'((k >= 15) && ((k - 15) % 5 == 0)));
      check("reprog_en0", 32'(en[0]), 32'(k % 3 == 0));
    end
    cfg_we = 1'b0;

    // Config write table, including out-of-range channels
    for (int v = 0; v < 5; v++) begin
      cfg_we = 1'b1; cfg_ch = tbl[v].ch; cfg_div = tbl[v].div;
      tick();
      check("cfg_err", 32'(cfg_err), 32'(tbl[v].exp_err));
      cfg_we = 1'b0;
      tick();
      check("cfg_err_clr", 32'(cfg_err), 32'd0);
    end
    for (int k = 0; k < 12; k++) tick();

    // Stop and resume with divide-by-4 on channel 0
    do_reset();
    write_cfg(3'd0, 32'd4);
    tick();
    tick();
    mode = 2'b00;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("stop_en", 32'(en), 32'd0);
    end
    mode = 2'b01;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("resume_en0", 32'(en[0]), 32'((k == 2) || (k == 6)));
    end

    // Single step: held switch gives one pulse three clocks after sampling
    do_reset();
    mode = 2'b10;
    step_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("step_en", 32'(en), (k == 4) ? 32'h1f : 32'h0);
      check("step_ack", 32'(step_ack), 32'(k == 4));
    end
    step_in = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    step_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) begin
        cfg_we = 1'b1; cfg_ch = 3'd1; cfg_div = 32'd4;
      end else begin
        cfg_we = 1'b0;
      end
      tick();
      check("step2_en", 32'(en), (k == 4) ? 32'h1f : 32'h0);
    end
    cfg_we = 1'b0;
    step_in = 1'b0;
    mode = 2'b01;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("post_step_en1", 32'(en[1]), 32'((k == 4) || (k == 8)));
      check("post_step_en0", 32'(en[0]), 32'(k % 3 == 0));
    end
    step_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("run_press_ack", 32'(step_ack), 32'd0);
    end
    mode = 2'b10;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("no_queue_ack", 32'(step_ack), 32'd0);
    end
    step_in = 1'b0;

    // Align: drift div=3 and div=6 apart, then restart in phase
    do_reset();
    write_cfg(3'd1, 32'd6);
    for (int k = 0; k < 7; k++) tick();
    mode = 2'b11;
    tick();
    check("align_en", 32'(en), 32'd0);
    check("align_tog", 32'(tog), 32'd0);
    mode = 2'b01;
    for (int k = 1; k <= 13; k++) begin
      tick();
      check("align_en0", 32'(en[0]), 32'(k % 3 == 0));
      check("align_en1", 32'(en[1]), 32'(k % 6 == 0));
      check("align_tog1", 32'(tog[1]), 32'((k >= 6) && (k < 12)));
    end

    // Disabled (div=0) and continuous (div=1) channels
    do_reset();
    write_cfg(3'd3, 32'd0);
    write_cfg(3'd4, 32'd1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("div0_en3", 32'(en[3]), 32'd0);
      check("div1_en4", 32'(en[4]), 32'd1);
    end
    mode = 2'b10;
    step_in = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("div0_step_en", 32'(en), (k == 4) ? 32'h17 : 32'h0);
    end
    step_in = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
